// File: rtl/bus_arbiter_pkg.sv
// Shared types for the core-boundary memory bus arbiter.
// Optional fetch-starvation guard is enabled with BUS_ARBITER_FAIRNESS_EN.
package bus_arbiter_pkg;

  typedef logic [31:0] data_word_t;

  // Store access size. Loads and fetches always move a whole aligned word;
  // the load unit extracts the byte or halfword itself.
  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } store_width_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } bus_arbiter_state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } bus_channel_t;

  function automatic data_word_t word_align(input data_word_t addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Channel interfaces between the core units (masters) and the bus arbiter (slave).
interface fetch_interface;
  import bus_arbiter_pkg::*;
  logic       request;
  data_word_t address;
  logic       invalidate;
  data_word_t instruction;
  logic       valid;
  logic       stall;

  modport master (output request, address, invalidate, input instruction, valid, stall);
  modport slave  (input request, address, invalidate, output instruction, valid, stall);
endinterface

interface load_interface;
  import bus_arbiter_pkg::*;
  logic       request;
  data_word_t address;
  logic       invalidate;
  data_word_t data;
  logic       valid;

  modport master (output request, address, invalidate, input data, valid);
  modport slave  (input request, address, invalidate, output data, valid);
endinterface

interface store_interface;
  import bus_arbiter_pkg::*;
  logic         request;
  data_word_t   address;
  data_word_t   data;
  store_width_t width;
  logic         done;

  modport master (output request, address, data, width, input done);
  modport slave  (input request, address, data, width, output done);
endinterface

// File: rtl/bus_arbiter_store_lane_aligner.sv
// Maps a store's width, byte offset and data onto the 32-bit bus lanes.
module store_lane_aligner
  import bus_arbiter_pkg::*;
(
  input  store_width_t width_i,
  input  logic [1:0]   offset_i,
  input  data_word_t   data_i,
  output logic [3:0]   byte_en_o,
  output data_word_t   wdata_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    byte_en_o = 4'b1111;
    wdata_o   = data_i;
    case (width_i)
      BYTE: begin
        byte_en_o = 4'b0001 << offset_i;
        wdata_o   = {4{data_i[7:0]}};
      end
      HALF_WORD: begin
        byte_en_o = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{data_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Fixed-priority arbiter (store > load > fetch) from three core channels onto one memory bus.
// BUS_ARBITER_FAIRNESS_EN adds a starvation counter that forces a fetch grant after three others.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_n_i,
  fetch_interface.slave  fetch_channel,
  load_interface.slave   load_channel,
  store_interface.slave  store_channel,
  output logic           mem_request_o,
  output logic           mem_write_o,
  output data_word_t     mem_address_o,
  output data_word_t     mem_wdata_o,
  output logic [3:0]     mem_byte_en_o,
  input  logic           mem_ready_i,
  input  logic           mem_valid_i,
  input  data_word_t     mem_rdata_i
);

  bus_arbiter_state_t state_q, state_d;
  bus_channel_t       grant_q, grant_d;
  logic               discard_q, discard_d;

  logic         fetch_pend_q, fetch_pend_d;
  data_word_t   fetch_addr_q, fetch_addr_d;
  logic         load_pend_q, load_pend_d;
  data_word_t   load_addr_q, load_addr_d;
  logic         store_pend_q, store_pend_d;
  data_word_t   store_addr_q, store_addr_d;
  data_word_t   store_data_q, store_data_d;
  store_width_t store_width_q, store_width_d;

  logic       mem_request_q, mem_request_d;
  logic       mem_write_q, mem_write_d;
  data_word_t mem_address_q, mem_address_d;
  data_word_t mem_wdata_q, mem_wdata_d;
  logic [3:0] mem_byte_en_q, mem_byte_en_d;

`ifdef BUS_ARBITER_FAIRNESS_EN
  logic [1:0] starve_q, starve_d;
`endif

  logic [3:0]   store_byte_en;
  data_word_t   store_wdata;
  logic         fetch_busy, load_busy, response, suppress;
  logic         any_pending;
  bus_channel_t winner;

  store_lane_aligner u_store_lane_aligner (
    .width_i   (store_width_q),
    .offset_i  (store_addr_q[1:0]),
    .data_i    (store_data_q),
    .byte_en_o (store_byte_en),
    .wdata_o   (store_wdata)
  );

  assign fetch_busy = (state_q != IDLE) && (grant_q == FETCH);
  assign load_busy  = (state_q != IDLE) && (grant_q == LOAD);
  assign response   = (state_q == WAIT) && mem_valid_i;

  always_comb begin
    any_pending = fetch_pend_q | load_pend_q | store_pend_q;
    winner      = FETCH;
    if (store_pend_q)     winner = STORE;
    else if (load_pend_q) winner = LOAD;
`ifdef BUS_ARBITER_FAIRNESS_EN
    if (fetch_pend_q && (starve_q == 2'd3)) winner = FETCH;
`endif
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    discard_d     = discard_q;
    fetch_pend_d  = fetch_pend_q;
    fetch_addr_d  = fetch_addr_q;
    load_pend_d   = load_pend_q;
    load_addr_d   = load_addr_q;
    store_pend_d  = store_pend_q;
    store_addr_d  = store_addr_q;
    store_data_d  = store_data_q;
    store_width_d = store_width_q;
    mem_request_d = mem_request_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
`ifdef BUS_ARBITER_FAIRNESS_EN
    starve_d      = starve_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_pending) begin
          state_d       = ISSUE;
          grant_d       = winner;
          discard_d     = 1'b0;
          mem_request_d = 1'b1;
          mem_write_d   = (winner == STORE);
          mem_wdata_d   = '0;
          mem_byte_en_d = '0;
          case (winner)
            FETCH: begin
              fetch_pend_d  = 1'b0;
              mem_address_d = word_align(fetch_addr_q);
            end
            LOAD: begin
              load_pend_d   = 1'b0;
              mem_address_d = word_align(load_addr_q);
            end
            default: begin
              store_pend_d  = 1'b0;
              mem_address_d = word_align(store_addr_q);
              mem_wdata_d   = store_wdata;
              mem_byte_en_d = store_byte_en;
            end
          endcase
`ifdef BUS_ARBITER_FAIRNESS_EN
          if (winner == FETCH)                      starve_d = 2'd0;
          else if (fetch_pend_q && starve_q != 2'd3) starve_d = starve_q + 2'd1;
`endif
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          state_d       = WAIT;
          mem_request_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Invalidate is applied before request so a same-cycle new request survives.
    if ((fetch_channel.invalidate && fetch_busy) || (load_channel.invalidate && load_busy))
      discard_d = 1'b1;
    if (fetch_channel.invalidate) fetch_pend_d = 1'b0;
    if (load_channel.invalidate)  load_pend_d  = 1'b0;

    if (fetch_channel.request) begin
      fetch_pend_d = 1'b1;
      fetch_addr_d = fetch_channel.address;
    end
    if (load_channel.request) begin
      load_pend_d = 1'b1;
      load_addr_d = load_channel.address;
    end
    if (store_channel.request) begin
      store_pend_d  = 1'b1;
      store_addr_d  = store_channel.address;
      store_data_d  = store_channel.data;
      store_width_d = store_channel.width;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all of it, payloads included, resets.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      grant_q       <= FETCH;
      discard_q     <= 1'b0;
      fetch_pend_q  <= 1'b0;
      fetch_addr_q  <= '0;
      load_pend_q   <= 1'b0;
      load_addr_q   <= '0;
      store_pend_q  <= 1'b0;
      store_addr_q  <= '0;
      store_data_q  <= '0;
      store_width_q <= BYTE;
      mem_request_q <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= '0;
`ifdef BUS_ARBITER_FAIRNESS_EN
      starve_q      <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      discard_q     <= discard_d;
      fetch_pend_q  <= fetch_pend_d;
      fetch_addr_q  <= fetch_addr_d;
      load_pend_q   <= load_pend_d;
      load_addr_q   <= load_addr_d;
      store_pend_q  <= store_pend_d;
      store_addr_q  <= store_addr_d;
      store_data_q  <= store_data_d;
      store_width_q <= store_width_d;
      mem_request_q <= mem_request_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
`ifdef BUS_ARBITER_FAIRNESS_EN
      starve_q      <= starve_d;
`endif
    end
  end

  assign mem_request_o = mem_request_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_address_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_byte_en_o = mem_byte_en_q;

  // A response whose channel was invalidated (earlier or right now) completes silently.
  assign suppress = discard_q |
                    ((grant_q == FETCH) ? fetch_channel.invalidate : load_channel.invalidate);

  assign fetch_channel.valid       = response && (grant_q == FETCH) && !suppress;
  assign fetch_channel.instruction = fetch_channel.valid ? mem_rdata_i : '0;
  assign fetch_channel.stall       = fetch_pend_q | (fetch_busy & ~response);
  assign load_channel.valid        = response && (grant_q == LOAD) && !suppress;
  assign load_channel.data         = load_channel.valid ? mem_rdata_i : '0;
  assign store_channel.done        = response && (grant_q == STORE);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Single-port memory arbiter between the core's three memory channels (fetch, load, store) and one external memory bus. Acts as slave on each channel interface, latches one pending request per channel, grants the external port to one channel at a time by fixed priority, and routes the response back. It sits at the core boundary, below the fetch unit and the load/store units.

## Interface
- No parameters; widths come from `data_word_t` (32 bit) and `store_width_t` (BYTE, HALF_WORD, WORD).
- `clk_i` in 1: core clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `fetch_channel` slave `fetch_interface`: instruction channel.
- `load_channel` slave `load_interface`: load channel.
- `store_channel` slave `store_interface`: store channel.
- `mem_request_o` out 1: external transaction request.
- `mem_write_o` out 1: 1 = write, 0 = read.
- `mem_address_o` out 32: word-aligned address (bits [1:0] = 0).
- `mem_wdata_o` out 32: lane-aligned write data.
- `mem_byte_en_o` out 4: write byte enables.
- `mem_ready_i` in 1: memory accepts the request this cycle.
- `mem_valid_i` in 1: read data valid, or write acknowledged.
- `mem_rdata_i` in 32: read data.

## Operation
- Pending registers, one per channel, hold the valid bit, the address, and for the store channel also data and width. A channel request pulse sets its pending bit and captures the payload.
- FSM states:
  - IDLE: if any pending bit is set, grant by priority store > load > fetch, clear that pending bit, go to ISSUE.
  - ISSUE: drive `mem_request_o` with the granted payload; on `mem_ready_i` go to WAIT.
  - WAIT: on `mem_valid_i`, route the response and go to IDLE.
- Response routing happens in the `mem_valid_i` cycle, combinationally:
  - fetch: `instruction = mem_rdata_i`, `valid = 1`.
  - load: `data = mem_rdata_i`, `valid = 1`.
  - store: `done = 1`.
- `fetch_channel.stall` = fetch pending, or fetch in ISSUE/WAIT.
- Store lane alignment, with a = address[1:0]:
  - BYTE: `byte_en = 1 << a`, data replicated in all four byte lanes.
  - HALF_WORD: `byte_en = 0011` when a[1]=0, `1100` when a[1]=1; data replicated in both halves.
  - WORD: `1111`.
- Loads and fetches return the full aligned word. The load unit extracts the byte or halfword.
- Invalidate (fetch or load):
  - Clears that channel's pending bit.
  - If that channel is in ISSUE/WAIT, sets a discard flag. The transaction still completes on the bus, but its `valid` is suppressed.
  - Invalidate and request in the same cycle: the new request is latched and only the old one is discarded.
- A request on a channel that is already pending or in flight is a protocol violation. The RTL overwrites the pending payload.
- Reset mid-operation: FSM goes to IDLE and all pending and discard bits clear. The external memory is reset by the same `rst_n_i`.

## Timing
- Reset values: `mem_request_o`=0, `mem_write_o`=0, `mem_address_o`=0, `mem_wdata_o`=0, `mem_byte_en_o`=0; all channel `valid`/`done`/`stall`=0; `instruction`/`data`=0.
- All `mem_*_o` outputs are registered. With request pulse at cycle T: pending at T+1, grant at T+1 (IDLE), `mem_request_o` high from T+2.
- `mem_request_o` and payload hold stable until `mem_ready_i` is sampled high.
- One transaction is outstanding at a time. After `mem_valid_i`, the next grant is issued one cycle later (IDLE), with `mem_request_o` the cycle after.
- Minimum request-to-response latency with a zero-wait memory: 3 cycles.
- A request arriving in the same cycle as its channel's response is latched normally.

## Configuration
- `BUS_ARBITER_FAIRNESS_EN` defined:
  - A 2-bit starvation counter increments on each store/load grant while fetch is pending, and clears on a fetch grant.
  - When the counter reaches 3, fetch wins the next arbitration.
- Not defined: strict priority store > load > fetch, and the counter is absent.

## Structure
- Add to `apogeo_pkg`: `bus_arbiter_state_t` enum (IDLE, ISSUE, WAIT) and `bus_channel_t` enum (FETCH, LOAD, STORE).
- Add the `store_width_t` usage note to `store_unit_pkg`.
- One sub-module, `store_lane_aligner`: combinational mapping from width, address and data to byte_en and wdata.

## Test plan
- Fetch at 0x100, zero-wait memory returns 0x00000013 -> `mem_request_o` rises T+2, fetch `valid` with 0x00000013 at T+3, `stall` high T+1..T+2.
- Load at 0x200 and fetch at 0x300 in the same cycle -> load issued first; fetch issued after load `valid`; fetch `stall` high throughout.
- Store BYTE 0xAB to 0x1003 -> `mem_address_o`=0x1000, `mem_byte_en_o`=1000, `mem_wdata_o`=0xABABABAB, `done` on ack.
- Load at 0x400 in WAIT, load invalidate -> memory returns 0xDEAD; no load `valid`; FSM returns to IDLE.
- `mem_ready_i` held low 5 cycles -> request and payload stable all 5 cycles.
- Fairness build, load request every cycle with fetch pending -> fetch granted after the 3rd load grant; without the macro, fetch waits until loads stop.
